// File: rtl/unidade_controle_jogo_tempo.sv
// Memory-game round controller with a per-play timeout.
// Moore FSM: sequences counter/register/compare for one round.
//
// Ports:
//   clock, reset  : rising-edge clock, async active-high reset
//   iniciar       : start/restart request (level)
//   jogada        : one-cycle pulse, a play was made
//   igual, fimC   : comparator match, counter at last position
//   zeraC, contaC : clear / increment address counter
//   zeraR         : clear play register
//   registraR     : load play register
//   pronto        : round finished
//   acertou       : round won
//   errou         : round lost by mismatch
//   timeout       : round lost by timeout
//   db_estado     : current state code for the display
module unidade_controle_jogo_tempo #(
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int W_TMO = $clog2(TIMEOUT_CICLOS)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARA     = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTO  = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERRO    = 4'hE
  } estado_t;

  localparam logic [W_TMO-1:0] TMO_MAX =
    W_TMO'(TIMEOUT_CICLOS - 1);

  estado_t          estado;
  estado_t          prox;
  logic [W_TMO-1:0] cnt_tmo;
  logic             expirou;

  assign expirou   = (cnt_tmo == TMO_MAX);
  assign db_estado = estado;

  // Next state; jogada takes priority over expiry.
  always_comb begin
    prox = INICIAL;
    unique case (estado)
      INICIAL:
        prox = iniciar ? PREPARA : INICIAL;
      PREPARA:
        prox = ESPERA;
      ESPERA:
        if (jogada)       prox = REGISTRA;
        else if (expirou) prox = FIM_TIMEOUT;
        else              prox = ESPERA;
      REGISTRA:
        prox = COMPARA;
      COMPARA:
        if (!igual)     prox = FIM_ERRO;
        else if (fimC)  prox = FIM_ACERTO;
        else            prox = PROXIMO;
      PROXIMO:
        prox = ESPERA;
      FIM_ACERTO:
        prox = iniciar ? PREPARA : FIM_ACERTO;
      FIM_TIMEOUT:
        prox = iniciar ? PREPARA : FIM_TIMEOUT;
      FIM_ERRO:
        prox = iniciar ? PREPARA : FIM_ERRO;
      default:
        prox = INICIAL;
    endcase
  end

  // Outputs are registered from the next state, so each
  // one is a pure decode of the state register's value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado    <= INICIAL;
      cnt_tmo   <= '0;
      zeraC     <= 1'b0;
      contaC    <= 1'b0;
      zeraR     <= 1'b0;
      registraR <= 1'b0;
      pronto    <= 1'b0;
      acertou   <= 1'b0;
      errou     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      estado <= prox;

      // Window restarts for every position; saturates.
      if (estado == PREPARA || estado == PROXIMO)
        cnt_tmo <= '0;
      else if (estado == ESPERA && !expirou)
        cnt_tmo <= cnt_tmo + W_TMO'(1);

      zeraC     <= (prox == PREPARA);
      zeraR     <= (prox == PREPARA);
      contaC    <= (prox == PROXIMO);
      registraR <= (prox == REGISTRA);
      acertou   <= (prox == FIM_ACERTO);
      errou     <= (prox == FIM_ERRO);
      timeout   <= (prox == FIM_TIMEOUT);
      pronto    <= (prox == FIM_ACERTO)
                || (prox == FIM_ERRO)
                || (prox == FIM_TIMEOUT);
    end
  end

endmodule

// File: tb/tb_unidade_controle_jogo_tempo.sv
// Directed bench for unidade_controle_jogo_tempo.
// Small datapath model: address counter, play register, memory.
module tb_unidade_controle_jogo_tempo;

  localparam int T = 8;

  logic       clock = 0;
  logic       reset = 0;
  logic       iniciar = 0;
  logic       jogada = 0;
  logic       igual;
  logic       fimC;
  logic       zeraC, contaC, zeraR, registraR;
  logic       pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  unidade_controle_jogo_tempo #(.TIMEOUT_CICLOS(T)) dut (
    .clock(clock), .reset(reset),
    .iniciar(iniciar), .jogada(jogada),
    .igual(igual), .fimC(fimC),
    .zeraC(zeraC), .contaC(contaC),
    .zeraR(zeraR), .registraR(registraR),
    .pronto(pronto), .acertou(acertou),
    .errou(errou), .timeout(timeout),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  logic [3:0] mem [16];
  logic [3:0] addr;
  logic [3:0] play_reg;
  logic [3:0] play_val = 0;
  int n_conta = 0;
  int n_reg = 0;
  int checks = 0;
  int passed = 0;

  assign igual = (play_reg == mem[addr]);
  assign fimC  = (addr == 4'd15);

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      addr     <= 0;
      play_reg <= 0;
    end else begin
      if (zeraC)       addr <= 0;
      else if (contaC) addr <= addr + 4'd1;
      if (zeraR)          play_reg <= 0;
      else if (registraR) play_reg <= play_val;
      if (contaC)    n_conta <= n_conta + 1;
      if (registraR) n_reg <= n_reg + 1;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] outs();
    return {zeraC, contaC, zeraR, registraR,
            pronto, acertou, errou, timeout};
  endfunction

  // From ESPERA: pulse jogada with value v, stop in COMPARA.
  task automatic to_compara(input logic [3:0] v);
    play_val = v;
    jogada = 1;
    step();
    jogada = 0;
    step();
  endtask

  task automatic pulse_iniciar();
    iniciar = 1;
    step();
    iniciar = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    #3;
    reset = 0;
    repeat (5) step();
    checks++;
    if (outs() !== 8'h00 || db_estado !== 4'h0)
      $display("FAIL reset_idle outs=%h st=%h want 00/0",
               outs(), db_estado);
    else passed++;
  endtask

  task automatic test_start();
    pulse_iniciar();
    checks++;
    if (db_estado !== 4'h1 || outs() !== 8'b1010_0000)
      $display("FAIL start_prepara st=%h outs=%b want 1/10100000",
               db_estado, outs());
    else passed++;
    step();
    checks++;
    if (db_estado !== 4'h2 || outs() !== 8'h00)
      $display("FAIL start_espera st=%h outs=%b want 2/0",
               db_estado, outs());
    else passed++;
  endtask

  task automatic test_win();
    int base = n_conta;
    int bad = 0;
    for (int i = 0; i < 16; i++) begin
      to_compara(mem[i]);
      step();
      if (i < 15) begin
        if (db_estado !== 4'h6 || contaC !== 1'b1) bad++;
        step();
      end
    end
    checks++;
    if (bad != 0)
      $display("FAIL win_proximo bad=%0d want 0", bad);
    else passed++;
    checks++;
    if (db_estado !== 4'hA || outs() !== 8'b0000_1100)
      $display("FAIL win_end st=%h outs=%b want A/00001100",
               db_estado, outs());
    else passed++;
    checks++;
    if (n_conta - base != 15)
      $display("FAIL win_conta got=%0d want 15", n_conta - base);
    else passed++;
    bad = 0;
    repeat (20) begin
      step();
      if (db_estado !== 4'hA || outs() !== 8'b0000_1100) bad++;
    end
    checks++;
    if (bad != 0)
      $display("FAIL win_hold bad=%0d want 0", bad);
    else passed++;
  endtask

  task automatic test_error();
    int base;
    pulse_iniciar();
    checks++;
    if (db_estado !== 4'h1 || pronto !== 1'b0 || acertou !== 1'b0)
      $display("FAIL err_restart st=%h pronto=%b acertou=%b want 1/0/0",
               db_estado, pronto, acertou);
    else passed++;
    step();
    base = n_conta;
    for (int i = 0; i < 3; i++) begin
      to_compara(mem[i]);
      step();
      step();
    end
    to_compara(mem[3] ^ 4'hF);
    step();
    checks++;
    if (db_estado !== 4'hE || outs() !== 8'b0000_1010)
      $display("FAIL err_end st=%h outs=%b want E/00001010",
               db_estado, outs());
    else passed++;
    checks++;
    if (n_conta - base != 3)
      $display("FAIL err_conta got=%0d want 3", n_conta - base);
    else passed++;
    pulse_iniciar();
    checks++;
    if (db_estado !== 4'h1)
      $display("FAIL err_to_prepara st=%h want 1", db_estado);
    else passed++;
    step();
    checks++;
    if (db_estado !== 4'h2 || outs() !== 8'h00)
      $display("FAIL err_to_espera st=%h outs=%b want 2/0",
               db_estado, outs());
    else passed++;
  endtask

  // Entered with the DUT on its first ESPERA cycle.
  task automatic test_timeout();
    repeat (T - 1) step();
    checks++;
    if (db_estado !== 4'h2)
      $display("FAIL tmo_last_wait st=%h want 2", db_estado);
    else passed++;
    step();
    checks++;
    if (db_estado !== 4'hD || outs() !== 8'b0000_1001)
      $display("FAIL tmo_end st=%h outs=%b want D/00001001",
               db_estado, outs());
    else passed++;
  endtask

  task automatic test_simultaneous();
    int base;
    pulse_iniciar();
    step();
    repeat (T - 1) step();
    base = n_reg;
    play_val = mem[0];
    jogada = 1;
    step();
    jogada = 0;
    checks++;
    if (db_estado !== 4'h4 || registraR !== 1'b1 || timeout !== 1'b0)
      $display("FAIL sim_jogada_wins st=%h reg=%b tmo=%b want 4/1/0",
               db_estado, registraR, timeout);
    else passed++;
    step();
    jogada = 1;
    step();
    jogada = 0;
    checks++;
    if (db_estado !== 4'h6 || registraR !== 1'b0)
      $display("FAIL sim_compara_jogada st=%h reg=%b want 6/0",
               db_estado, registraR);
    else passed++;
    step();
    step();
    checks++;
    if (db_estado !== 4'h2 || n_reg - base != 1)
      $display("FAIL sim_no_extra st=%h regs=%0d want 2/1",
               db_estado, n_reg - base);
    else passed++;
  endtask

  task automatic test_async_reset();
    to_compara(mem[1]);
    checks++;
    if (db_estado !== 4'h5)
      $display("FAIL ar_in_compara st=%h want 5", db_estado);
    else passed++;
    #2;
    reset = 1;
    #1;
    checks++;
    if (db_estado !== 4'h0 || outs() !== 8'h00)
      $display("FAIL ar_immediate st=%h outs=%b want 0/0",
               db_estado, outs());
    else passed++;
    #1;
    reset = 0;
    repeat (4) step();
    checks++;
    if (db_estado !== 4'h0 || outs() !== 8'h00)
      $display("FAIL ar_stays_idle st=%h outs=%b want 0/0",
               db_estado, outs());
    else passed++;
    pulse_iniciar();
    checks++;
    if (db_estado !== 4'h1 || zeraC !== 1'b1)
      $display("FAIL ar_restart st=%h zeraC=%b want 1/1",
               db_estado, zeraC);
    else passed++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++)
      mem[i] = 4'((i * 5 + 3) % 16);
    test_reset();
    test_start();
    test_win();
    test_error();
    test_timeout();
    test_simultaneous();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
